// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// access-size decode and the data-memory base address.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] DATA_BASE = 32'h10010000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        DONE
    } lsuState_t;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } accessSize_t;

    // Reserved funct3 encodings fall through to a full word access.
    function automatic accessSize_t accessSize(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SIZE_B;
            F3_H, F3_HU: return SIZE_H;
            default:     return SIZE_W;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (accessSize(funct3))
            SIZE_B:  return 1'b0;
            SIZE_H:  return lane[0];
            default: return (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bus of the load/store unit.
interface lsu_if;
    import lsu_pkg::*;

    logic            iReq;
    logic            iWrite;
    logic [2:0]      iFunct3;
    logic [XLEN-1:0] iAddress;
    logic [XLEN-1:0] iData;
    logic            oReady;
    logic            oDone;
    logic [XLEN-1:0] oData;
    logic            oFault;

    modport master (
        output iReq, iWrite, iFunct3, iAddress, iData,
        input  oReady, oDone, oData, oFault
    );

    modport slave (
        input  iReq, iWrite, iFunct3, iAddress, iData,
        output oReady, oDone, oData, oFault
    );

endinterface

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends load data from a memory word and merges
// sub-word store data into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] memWord,
    input  logic [XLEN-1:0] storeData,
    output logic [XLEN-1:0] loadData,
    output logic [XLEN-1:0] mergeData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal   = memWord[{lane, 3'b000} +: 8];
        halfVal   = memWord[{lane[1], 4'b0000} +: 16];
        loadData  = memWord;
        mergeData = storeData;
        case (accessSize(funct3))
            SIZE_B: begin
                loadData = funct3[2] ? {24'h000000, byteVal} : {{24{byteVal[7]}}, byteVal};
                mergeData = memWord;
                mergeData[{lane, 3'b000} +: 8] = storeData[7:0];
            end
            SIZE_H: begin
                loadData = funct3[2] ? {16'h0000, halfVal} : {{16{halfVal[15]}}, halfVal};
                mergeData = memWord;
                mergeData[{lane[1], 4'b0000} +: 16] = storeData[15:0];
            end
            default: begin
                loadData  = memWord;
                mergeData = storeData;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory; sub-word stores
// use read-modify-write. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    lsu_if.slave            core,
    output logic            oMemRead,
    output logic            oMemWrite,
    output logic [XLEN-1:0] oMemAddress,
    output logic [XLEN-1:0] oMemData,
    input  logic [XLEN-1:0] iMemData
);

    lsuState_t       state;
    lsuState_t       nextState;
    logic            accept;
    logic            misaligned;

    logic [XLEN-1:0] addrQ;
    logic [2:0]      funct3Q;
    logic [XLEN-1:0] dataQ;
    logic            readyQ;
    logic            doneQ;
    logic            memReadQ;
    logic            memWriteQ;
    logic [XLEN-1:0] loadDataQ;
    logic [XLEN-1:0] memDataQ;
    logic [XLEN-1:0] loadData;
    logic [XLEN-1:0] mergeData;

    lsu_align align (
        .funct3    (funct3Q),
        .lane      (addrQ[1:0]),
        .memWord   (iMemData),
        .storeData (dataQ),
        .loadData  (loadData),
        .mergeData (mergeData)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState  = state;
        accept     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = isMisaligned(core.iFunct3, core.iAddress[1:0]);
`else
        misaligned = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (core.iReq) begin
                    accept = 1'b1;
                    if (misaligned)                            nextState = DONE;
                    else if (!core.iWrite)                     nextState = LOAD;
                    else if (accessSize(core.iFunct3) == SIZE_W) nextState = STORE;
                    else                                       nextState = RMW_RD;
                end
            end
            LOAD:    nextState = DONE;
            STORE:   nextState = DONE;
            RMW_RD:  nextState = RMW_WR;
            RMW_WR:  nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            addrQ     <= '0;
            funct3Q   <= '0;
            dataQ     <= '0;
            readyQ    <= 1'b1;
            doneQ     <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            loadDataQ <= '0;
            memDataQ  <= '0;
        end else begin
            readyQ    <= (nextState == IDLE);
            doneQ     <= (nextState == DONE);
            memReadQ  <= (nextState == LOAD)  || (nextState == RMW_RD);
            memWriteQ <= (nextState == STORE) || (nextState == RMW_WR);
            if (accept) begin
                addrQ    <= core.iAddress;
                funct3Q  <= core.iFunct3;
                dataQ    <= core.iData;
                memDataQ <= core.iData;
            end
            if (state == LOAD)   loadDataQ <= loadData;
            if (state == RMW_RD) memDataQ  <= mergeData;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic faultQ;

    always_ff @(posedge clock) begin
        if (reset)       faultQ <= 1'b0;
        else if (accept) faultQ <= misaligned;
    end

    assign core.oFault = faultQ;
`else
    assign core.oFault = 1'b0;
`endif

    assign core.oReady  = readyQ;
    assign core.oDone   = doneQ;
    assign core.oData   = loadDataQ;
    assign oMemRead     = memReadQ;
    // A reset landing on a write cycle must not commit the write.
    assign oMemWrite    = memWriteQ & ~reset;
    assign oMemAddress  = {addrQ[XLEN-1:2], 2'b00};
    assign oMemData     = memDataQ;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and DataMemory, which is word-addressed only. Turns RV32I loads and stores (lb, lh, lw, lbu, lhu, sb, sh, sw) into word accesses. Sub-word stores become a two-cycle read-modify-write. Loads are sign- or zero-extended. Busy is exposed to the core through a ready/done handshake.

## Interface
- BASE, 32'h10010000: byte address of data memory word 0. Used only for the misalignment/range decode.
- clock  in  1  system clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- iReq  in  1  core request strobe. Sampled only while oReady=1.
- iWrite  in  1  1 = store, 0 = load.
- iFunct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- iAddress  in  32  byte address.
- iData  in  32  store data (low byte/half used for sb/sh).
- oReady  out  1  unit idle, request will be accepted.
- oDone  out  1  one-cycle pulse: operation complete.
- oData  out  32  extended load result. Valid when oDone=1.
- oFault  out  1  misaligned access. Valid when oDone=1.
- oMemRead  out  1  to DataMemory read.
- oMemWrite  out  1  to DataMemory write.
- oMemAddress  out  32  word-aligned byte address (iAddress with bits [1:0] cleared).
- oMemData  out  32  write word to DataMemory.
- iMemData  in  32  asynchronous read data from DataMemory.

## Operation
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE.
- In IDLE, oReady=1. On iReq:
  - Latch address, funct3, data and iWrite.
  - Go to LOAD (any load), STORE (sw) or RMW_RD (sb/sh).
  - Misaligned access goes to DONE with fault set.
- LOAD: oMemRead=1. Capture the extracted and extended iMemData into the oData register. Go to DONE.
- STORE: oMemWrite=1, oMemRead=0, oMemData=latched iData. Go to DONE.
- RMW_RD: oMemRead=1. Capture iMemData into the merge register. Go to RMW_WR.
- RMW_WR: oMemWrite=1, oMemRead=0. oMemData = captured word with the addressed byte or half replaced. Go to DONE.
- DONE: oDone=1. Return to IDLE.
- oMemRead and oMemWrite are never high together.
- Byte lane = address[1:0]. Half lane = address[1] (little-endian).
- Extension:
  - b/h sign-extend from bit 7/15.
  - bu/hu zero-extend.
  - w passes through.
- Misaligned means h/hu/sh with addr[0]=1, or w/sw with addr[1:0]≠0. See Configuration for handling.
- Unused funct3 values (011, 110, 111) are treated as w.
- iReq while oReady=0 is ignored. The core holds its request until accepted.
- Reset values: state IDLE, oData=0, oFault=0, oDone=0, oMemRead=0, oMemWrite=0, oMemData=0.
- oMemWrite is gated with !reset, so reset asserted during STORE/RMW_WR issues no write.
- Reset mid-operation aborts the operation. No oDone pulse for the aborted operation.

## Timing
- Edge E0 accepts the request.
- lw/lb/lh/lbu/lhu: read during cycle E0–E1. oDone in cycle E1–E2 (latency 2).
- sw: write committed at E1. oDone in cycle E1–E2 (latency 2).
- sb/sh: read E0–E1, write committed at E2. oDone in cycle E2–E3 (latency 3).
- Misaligned with fault enabled: oDone in cycle E0–E1 (latency 1). No memory access.
- Next request accepted at the edge after the DONE cycle. Maximum throughput is one op per 3 cycles (4 for sb/sh).
- oData holds its value until the next load completes.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests skip memory and complete with oFault=1, oData unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misalignment detection is compiled out and oFault is tied 0.
  - Low address bits beyond the access size are ignored (h uses addr[1], w uses none).
  - The access proceeds normally.

## Structure
- Shared package lsu_pkg:
  - funct3 encoding constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - DATA_BASE constant (32'h10010000).
- One sub-module, lsu_align (combinational):
  - Load path: extract and extend from word, funct3 and addr[1:0].
  - Store path: merge store data into the read word.
- load_store_unit holds the FSM and all registers.

## Test plan
- Memory word 1 = 100. lw 0x10010004 → oDone 2 cycles after accept, oData=0x00000064, no oMemWrite.
- Memory word 3 = 305:
  - lb 0x1001000C → 0x31.
  - lb 0x1001000D → 0x01.
  - lh 0x1001000C → 0x0131.
  - lhu 0x1001000E → 0x0000.
- sb iData=0xFF to 0x10010005 → oMemWrite exactly one cycle, word 1 becomes 0x0000FF64. Then:
  - lb 0x10010005 → 0xFFFFFFFF.
  - lbu 0x10010005 → 0x000000FF.
- sh iData=0x1234ABCD to 0x10010002 → word 0 becomes 0xABCD0000. Then lh 0x10010002 → 0xFFFFABCD, lw 0x10010000 → 0xABCD0000.
- lw 0x10010006:
  - With LSU_MISALIGN_TRAP_EN: oFault=1, oDone 1 cycle after accept, oMemRead/oMemWrite never high.
  - Without: oData = word 1, oFault=0.
- sb 0x10010008 iData=0x77, reset asserted during RMW_WR → oMemWrite stays 0, word 2 remains 50, no oDone, oReady=1 the cycle after reset.
